// File: rtl/req_encoder_pkg.sv
// req_encoder_pkg: shared widths, FSM state type and popcount helper for req_encoder
package req_encoder_pkg;
  localparam int N_REQ = 32;
  localparam int IDX_W = 5;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic logic [IDX_W:0] popcount(input logic [N_REQ-1:0] v);
    popcount = '0;
    for (int i = 0; i < N_REQ; i++) popcount += {{IDX_W{1'b0}}, v[i]};
  endfunction
endpackage

// File: rtl/req_encoder_if.sv
// req_encoder_if: request/grant bundle between a requester (master) and req_encoder (slave)
interface req_encoder_if;
  import req_encoder_pkg::*;
  logic [N_REQ-1:0] req;
  logic en;
  logic ack;
  logic [IDX_W-1:0] idx;
  logic valid;
  logic [IDX_W:0] pend_cnt;
  modport master (output req, en, ack, input idx, valid, pend_cnt);
  modport slave (input req, en, ack, output idx, valid, pend_cnt);
endinterface

// File: rtl/req_encoder_lsb_find32.sv
// lsb_find32: combinational index of the lowest set bit of a 32-bit vector
module lsb_find32 (
  input  logic [31:0] vec,
  output logic [4:0]  idx,
  output logic        any
);
  always_comb begin
    idx = '0;
    for (int i = 31; i >= 0; i--) idx = vec[i] ? 5'(i) : idx;
    any = |vec;
  end
endmodule

// File: rtl/req_encoder.sv
// req_encoder: captures level requests as pending bits and grants them lowest-index first
module req_encoder #(
  parameter int N_REQ = 32,
  parameter int IDX_W = 5
) (
  input logic clk,
  input logic reset_n,
  req_encoder_if.slave bus
);
  import req_encoder_pkg::*;
  state_t state_q, state_d;
  logic [N_REQ-1:0] pending_q, pending_d, clr_mask;
  logic [IDX_W-1:0] idx_q, idx_d, lsb_idx;
  logic [IDX_W:0] cnt_q, cnt_d;
  logic lsb_any;
  lsb_find32 u_lsb (.vec(pending_q), .idx(lsb_idx), .any(lsb_any));
  // OR-ing req after the clear lets a same-edge request win over the ack clear
  always_comb begin
    clr_mask = (state_q == GRANT && bus.ack) ? N_REQ'(1) << idx_q : '0;
    pending_d = (pending_q & ~clr_mask) | bus.req;
    cnt_d = popcount(pending_d);
    state_d = state_q;
    idx_d = idx_q;
    if (state_q == IDLE && bus.en && lsb_any) begin
      state_d = GRANT;
      idx_d = lsb_idx;
    end else if (state_q == GRANT && bus.ack) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pending_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.idx = idx_q;
  assign bus.valid = (state_q == GRANT);
  assign bus.pend_cnt = cnt_q;
endmodule
